// File: rtl/h75_panel_driver_if.sv
// Framebuffer read port of the HUB75 panel driver: {row, col} address and buffer
// select go out, the pixel word comes back exactly one clock later.
interface h75_panel_driver_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 48
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_buf;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_addr, output rd_buf, input rd_data);
    modport slave  (input rd_addr, input rd_buf, output rd_data);
endinterface

// File: rtl/h75_panel_driver.sv
// HUB75 LED panel scan driver with binary-coded-modulation bit planes and global dimming.
// Define H75_DOUBLE_BUFFER_EN to enable framebuffer swapping at frame boundaries.
module h75_panel_driver #(
    parameter int COLOR_BITS    = 8,
    parameter int ROW_ADDR_BITS = 5,
    parameter int CHAINS        = 1,
    parameter int BASE_TICKS    = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [9:0]               pixels_per_row,
    input  logic [7:0]               brightness,
    input  logic                     buf_swap_req,
    h75_panel_driver_if.master       fb,
    output logic [CHAINS*6-1:0]      rgb,
    output logic                     led_clk,
    output logic                     latch_enable,
    output logic                     plane_oe,
    output logic [ROW_ADDR_BITS-1:0] ABCDE,
    output logic                     frame_sync,
    output logic                     buf_swap_ack,
    output logic                     busy
);
    localparam int PLANE_W   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int MAX_TICKS = BASE_TICKS << (COLOR_BITS - 1);
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(COLOR_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, LATCH} state_t;

    state_t                   state, state_nxt;
    logic                     phase;
    logic [9:0]               col;
    logic [PLANE_W-1:0]       plane;
    logic [ROW_ADDR_BITS-1:0] row, abcde_q, adv_row;
    logic [CNT_W-1:0]         disp_cnt, off_thresh, load_ticks, on_ticks;
    logic [CNT_W+7:0]         on_prod;
    logic [9:0]               ppr_q;
    logic [7:0]               bri_q;
    logic                     stopping;
    logic [CHAINS*6-1:0]      rgb_plane;
    logic                     last_col, plane_last, frame_end, expiring, stop_req;

    assign last_col   = (col == ppr_q - 10'd1);
    assign plane_last = (plane == LAST_PLANE);
    assign frame_end  = plane_last && (row == '1);
    // The count reaches zero on the next edge, so moving now lands LATCH on zero.
    assign expiring   = (disp_cnt <= CNT_W'(1));
    assign stop_req   = !enable || (pixels_per_row == 10'd0);
    assign adv_row    = plane_last ? row + 1'b1 : row;

    assign load_ticks = CNT_W'(BASE_TICKS) << plane;
    assign on_prod    = (CNT_W + 8)'(load_ticks) * (CNT_W + 8)'(bri_q);
    assign on_ticks   = on_prod[CNT_W+7:8];

    always_comb begin
        rgb_plane = '0;
        for (int i = 0; i < CHAINS * 6; i++)
            rgb_plane[i] = fb.rd_data[i*COLOR_BITS + int'(plane)];
    end

    // NOTE: state-holding elements use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first; a missing branch
    // would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable && pixels_per_row != 10'd0) state_nxt = SHIFT;
            SHIFT: if (phase && last_col) state_nxt = expiring ? LATCH : WAIT;
            WAIT:  if (expiring) state_nxt = stopping ? IDLE : LATCH;
            LATCH: state_nxt = (frame_end && stop_req) ? WAIT : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        led_clk      = (state == SHIFT) && phase;
        latch_enable = (state == LATCH);
        busy         = (state != IDLE);
        frame_sync   = (state == LATCH) && frame_end;
        ABCDE        = (state == LATCH) ? row : abcde_q;
        plane_oe     = (state == IDLE) || (state == LATCH) || (disp_cnt <= off_thresh);
        case (state)
            SHIFT:   fb.rd_addr = {row, phase ? col + 10'd1 : col};
            LATCH:   fb.rd_addr = {adv_row, 10'd0};
            default: fb.rd_addr = {row, 10'd0};
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase      <= 1'b0;
            col        <= '0;
            plane      <= '0;
            row        <= '0;
            abcde_q    <= '0;
            disp_cnt   <= '0;
            off_thresh <= '0;
            ppr_q      <= '0;
            bri_q      <= '0;
            stopping   <= 1'b0;
            rgb        <= '0;
        end else begin
            if (state == LATCH)      disp_cnt <= load_ticks;
            else if (disp_cnt != '0) disp_cnt <= disp_cnt - 1'b1;

            case (state)
                IDLE: begin
                    stopping <= 1'b0;
                    phase    <= 1'b0;
                    col      <= '0;
                    if (state_nxt == SHIFT) begin
                        ppr_q <= pixels_per_row;
                        bri_q <= brightness;
                    end
                end
                SHIFT: begin
                    if (!phase) begin
                        rgb   <= rgb_plane;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        col   <= last_col ? 10'd0 : col + 10'd1;
                    end
                end
                LATCH: begin
                    abcde_q    <= row;
                    off_thresh <= load_ticks - on_ticks;
                    plane      <= plane_last ? '0 : plane + 1'b1;
                    row        <= adv_row;
                    if (frame_end) begin
                        ppr_q    <= pixels_per_row;
                        bri_q    <= brightness;
                        stopping <= stop_req;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef H75_DOUBLE_BUFFER_EN
    logic rd_buf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                           rd_buf_q <= 1'b0;
        else if (frame_sync && buf_swap_req)   rd_buf_q <= ~rd_buf_q;
    end

    assign fb.rd_buf    = rd_buf_q;
    assign buf_swap_ack = frame_sync && buf_swap_req;
`else
    logic unused_swap_req;

    assign unused_swap_req = buf_swap_req;
    assign fb.rd_buf       = 1'b0;
    assign buf_swap_ack    = 1'b0;
`endif
endmodule

// File: tb/tb_h75_panel_driver.sv
// Scoreboard bench for h75_panel_driver: stimulus queues expected shifts and latches,
// a negedge monitor pops and compares them as the panel interface produces them.
module tb_h75_panel_driver;
    localparam int CB     = 2;
    localparam int RAB    = 1;
    localparam int CH     = 1;
    localparam int BT     = 4;
    localparam int ADDR_W = RAB + 10;
    localparam int DATA_W = CH * 6 * CB;
`ifdef H75_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetn = 1'b1;
    logic           enable = 1'b0;
    logic [9:0]     pixels_per_row = 10'd4;
    logic [7:0]     brightness = 8'd255;
    logic           buf_swap_req = 1'b0;
    logic [CH*6-1:0] rgb;
    logic           led_clk, latch_enable, plane_oe, frame_sync, buf_swap_ack, busy;
    logic [RAB-1:0] ABCDE;

    h75_panel_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fb ();

    h75_panel_driver #(
        .COLOR_BITS(CB), .ROW_ADDR_BITS(RAB), .CHAINS(CH), .BASE_TICKS(BT)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .pixels_per_row(pixels_per_row), .brightness(brightness),
        .buf_swap_req(buf_swap_req), .fb(fb), .rgb(rgb), .led_clk(led_clk),
        .latch_enable(latch_enable), .plane_oe(plane_oe), .ABCDE(ABCDE),
        .frame_sync(frame_sync), .buf_swap_ack(buf_swap_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Framebuffer model: one-cycle read latency; addr_qq is the address whose data
    // the driver consumed for the column currently being clocked out.
    int              mode = 0;
    logic [ADDR_W-1:0] addr_q = '0, addr_qq = '0;
    logic [5:0]      mem_p0, mem_p1;

    function automatic logic [5:0] pat(input int m, input int p, input logic [ADDR_W-1:0] a);
        logic       r;
        logic [1:0] c;
        logic [5:0] p0;
        r = a[10];
        c = a[1:0];
        if (m == 0) return (p != 0) ? 6'h3F : 6'h00;
        p0 = {r, c, ~r, ~c};
        return (p != 0) ? {p0[2:0], p0[5:3]} : p0;
    endfunction

    always @(posedge clk) begin
        addr_q  <= fb.rd_addr;
        addr_qq <= addr_q;
    end

    assign mem_p0 = pat(mode, 0, addr_q);
    assign mem_p1 = pat(mode, 1, addr_q);

    always_comb begin
        fb.rd_data = '0;
        for (int k = 0; k < 6; k++) fb.rd_data[k*CB +: CB] = {mem_p1[k], mem_p0[k]};
    end

    typedef struct packed {
        logic [5:0]        rgb;
        logic [ADDR_W-1:0] addr;
    } shift_exp_t;

    typedef struct packed {
        logic [RAB-1:0] row;
        logic           fsync;
        logic           ack;
        logic           buf_sel;
        logic           chk_gap;
        logic           chk_fsp;
        logic [3:0]     oe_low;
    } latch_exp_t;

    shift_exp_t shift_q[$];
    latch_exp_t latch_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit mon_on = 1'b0;
    int rises, oe_low, latches, fsyncs, acks, last_latch, last_fsync;
    logic exp_buf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        shift_exp_t se;
        latch_exp_t le;
        if (mon_on) begin
            if (led_clk) begin
                rises++;
                check("shift_expected", shift_q.size() != 0, 1);
                if (shift_q.size() != 0) begin
                    se = shift_q.pop_front();
                    check("rgb", rgb, se.rgb);
                    check("rd_addr_consumed", addr_qq, se.addr);
                end
            end
            if (!plane_oe)    oe_low++;
            if (frame_sync)   fsyncs++;
            if (buf_swap_ack) acks++;
            if (latch_enable) begin
                check("latch_expected", latch_q.size() != 0, 1);
                if (latch_q.size() != 0) begin
                    le = latch_q.pop_front();
                    check("abcde", ABCDE, le.row);
                    check("frame_sync", frame_sync, le.fsync);
                    check("buf_swap_ack", buf_swap_ack, le.ack);
                    check("rd_buf", fb.rd_buf, le.buf_sel);
                    check("rises_per_latch", rises, 4);
                    check("oe_low_cycles", oe_low, le.oe_low);
                    if (le.chk_gap) check("latch_period", cyc - last_latch, 9);
                    if (le.fsync) begin
                        if (le.chk_fsp) check("frame_period", cyc - last_fsync, 36);
                        last_fsync = cyc;
                    end
                end
                latches++;
                rises      = 0;
                oe_low     = 0;
                last_latch = cyc;
            end
        end
    end

    // One run: queue the expected frames, enable, drop enable mid last frame, drain.
    task automatic run(input int m, input logic [7:0] bri, input int on0, input int on1,
                       input int frames, input logic req);
        int guard;
        logic [ADDR_W-1:0] a;
        latch_exp_t le;
        mode = m;
        brightness = bri;
        buf_swap_req = req;
        pixels_per_row = 10'd4;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < 4; i++) begin
                for (int c = 0; c < 4; c++) begin
                    a = {RAB'(i / 2), 10'(c)};
                    shift_q.push_back('{rgb: pat(m, i % 2, a), addr: a});
                end
                le.row     = RAB'(i / 2);
                le.fsync   = (i == 3);
                le.ack     = DB && req && (i == 3);
                le.buf_sel = exp_buf;
                le.chk_gap = !(f == 0 && i == 0);
                le.chk_fsp = (i == 3) && (f > 0);
                le.oe_low  = (f == 0 && i == 0) ? 4'd0 : 4'((i % 2 == 1) ? on0 : on1);
                latch_q.push_back(le);
                if (DB && req && i == 3) exp_buf = ~exp_buf;
            end
        end
        rises = 0; oe_low = 0; latches = 0; fsyncs = 0; acks = 0;
        mon_on = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        guard = 0;
        while (latches < 4 * (frames - 1) + 1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("run_progress_in_time", guard < 2000, 1);
        enable = 1'b0;
        guard = 0;
        while (busy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_in_time", guard < 2000, 1);
        repeat (3) @(negedge clk);
        check("shift_q_drained", shift_q.size(), 0);
        check("latch_q_drained", latch_q.size(), 0);
        check("frame_sync_count", fsyncs, frames);
        check("swap_ack_count", acks, (DB && req) ? frames : 0);
        check("final_plane_oe_low", oe_low, on1);
        check("idle_no_led_clk", rises, 0);
        check("idle_busy", busy, 0);
        check("idle_plane_oe", plane_oe, 1);
        check("idle_rd_buf", fb.rd_buf, exp_buf);
        mon_on = 1'b0;
        buf_swap_req = 1'b0;
        shift_q.delete();
        latch_q.delete();
    endtask

    initial begin
        int guard, seen;
        #1 resetn = 1'b0;
        #2;
        check("rst_plane_oe", plane_oe, 1);
        check("rst_led_clk", led_clk, 0);
        check("rst_latch", latch_enable, 0);
        check("rst_abcde", ABCDE, 0);
        check("rst_busy", busy, 0);
        check("rst_rgb", rgb, 0);
        check("rst_rd_addr", fb.rd_addr, 0);
        check("rst_rd_buf", fb.rd_buf, 0);
        check("rst_frame_sync", frame_sync, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run(1, 8'd255, 3, 7, 2, 1'b0);
        run(0, 8'd128, 2, 4, 1, 1'b0);
        run(1, 8'd0,   0, 0, 1, 1'b0);
        run(1, 8'd255, 3, 7, 2, 1'b1);

        // Reset while shifting row 1: everything must clear at once, no latch follows.
        mode = 1;
        enable = 1'b1;
        seen = 0;
        guard = 0;
        while (seen < 3 && guard < 500) begin
            @(negedge clk);
            if (latch_enable) seen++;
            guard++;
        end
        check("pre_reset_progress", guard < 500, 1);
        repeat (2) @(negedge clk);
        check("pre_reset_abcde", ABCDE, 1);
        check("pre_reset_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_plane_oe", plane_oe, 1);
        check("midrst_led_clk", led_clk, 0);
        check("midrst_latch", latch_enable, 0);
        check("midrst_abcde", ABCDE, 0);
        check("midrst_busy", busy, 0);
        exp_buf = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("midrst_next_plane_oe", plane_oe, 1);
        check("midrst_next_busy", busy, 0);
        check("midrst_rd_buf", fb.rd_buf, exp_buf);
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (latch_enable || busy) seen++;
        end
        check("post_reset_quiet", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
